// File: rtl/beat_player_ctrl_if.sv
// Control and status bundle between the player front end and the beat sequencer.
// The front end drives commands and song parameters; the sequencer returns beat status.
interface beat_player_ctrl_if #(
  parameter int unsigned BEAT_W = 8,
  parameter int unsigned DIV_W  = 24
);
  logic              play;
  logic              pause;
  logic              stop;
  logic              loop;
  logic [BEAT_W-1:0] song_len;
  logic [DIV_W-1:0]  tempo_div;
  logic [BEAT_W-1:0] ibeat;
  logic              beat_strobe;
  logic              playing;
  logic              paused;
  logic              done;

  modport master (
    output play, pause, stop, loop, song_len, tempo_div,
    input  ibeat, beat_strobe, playing, paused, done
  );

  modport slave (
    input  play, pause, stop, loop, song_len, tempo_div,
    output ibeat, beat_strobe, playing, paused, done
  );
endinterface

// File: rtl/beat_player_ctrl.sv
// Beat sequencer: programmable tempo divider, play/pause/stop control, optional looping
// and end-of-song signalling. Produces the beat index for the note ROM and tone generators.
module beat_player_ctrl #(
  parameter int unsigned BEAT_W = 8,
  parameter int unsigned DIV_W  = 24
) (
  input  logic               clk,
  input  logic               rst,
  beat_player_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [BEAT_W-1:0] ibeat_q, ibeat_n;
  logic [BEAT_W-1:0] len_q, len_n;
  logic [DIV_W-1:0]  div_q, div_n;
  logic [DIV_W-1:0]  div_cnt, div_cnt_n;
  logic              strobe_q, strobe_n;
  logic              done_q, done_n;
  logic              playing_q, paused_q;
  logic              tick;
  logic              last_beat;

  assign tick      = (div_cnt == div_q);
  assign last_beat = (ibeat_q == BEAT_W'(len_q - BEAT_W'(1)));

  // State and datapath registers; status flags track the next state so they stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ibeat_q   <= '0;
      len_q     <= '0;
      div_q     <= '0;
      div_cnt   <= '0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      playing_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      state     <= state_n;
      ibeat_q   <= ibeat_n;
      len_q     <= len_n;
      div_q     <= div_n;
      div_cnt   <= div_cnt_n;
      strobe_q  <= strobe_n;
      done_q    <= done_n;
      playing_q <= (state_n == PLAY);
      paused_q  <= (state_n == PAUSE);
    end
  end

  // Command decode with stop > play > pause priority, then free-running beat advance.
  always_comb begin
    state_n   = state;
    ibeat_n   = ibeat_q;
    len_n     = len_q;
    div_n     = div_q;
    div_cnt_n = div_cnt;
    strobe_n  = 1'b0;
    done_n    = 1'b0;

    if (bus.stop) begin
      state_n   = IDLE;
      ibeat_n   = '0;
      div_cnt_n = '0;
    end else if (bus.play) begin
      if (state == PAUSE) begin
        state_n = PLAY;
      end else if (bus.song_len != '0) begin
        state_n   = PLAY;
        len_n     = bus.song_len;
        div_n     = bus.tempo_div;
        ibeat_n   = '0;
        div_cnt_n = '0;
        strobe_n  = 1'b1;
      end else if (state == PLAY) begin
        // Zero-length start while playing behaves as stop.
        state_n   = IDLE;
        ibeat_n   = '0;
        div_cnt_n = '0;
      end
    end else if (bus.pause) begin
      if (state == PLAY) begin
        state_n = PAUSE;
      end else if (state == PAUSE) begin
        state_n = PLAY;
      end
    end else if (state == PLAY) begin
      if (!tick) begin
        div_cnt_n = div_cnt + DIV_W'(1);
      end else begin
        div_cnt_n = '0;
        if (!last_beat) begin
          ibeat_n  = ibeat_q + BEAT_W'(1);
          strobe_n = 1'b1;
        end else if (bus.loop) begin
          ibeat_n  = '0;
          strobe_n = 1'b1;
          done_n   = 1'b1;
        end else begin
          // Park on the end marker (== song length) until the next command.
          ibeat_n = len_q;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
    end
  end

  assign bus.ibeat       = ibeat_q;
  assign bus.beat_strobe = strobe_q;
  assign bus.playing     = playing_q;
  assign bus.paused      = paused_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_beat_player_ctrl.sv
// Bench for beat_player_ctrl: directed scenarios plus randomized command traffic,
// every cycle compared against a countdown-based behavioural player model.
module tb_beat_player_ctrl;

  localparam int unsigned BEAT_W = 8;
  localparam int unsigned DIV_W  = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  beat_player_ctrl_if #(.BEAT_W(BEAT_W), .DIV_W(DIV_W)) bus ();

  beat_player_ctrl #(.BEAT_W(BEAT_W), .DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Player model: mode 0 = stopped, 1 = playing, 2 = paused; m_left = cycles until next beat.
  int m_mode, m_beat, m_left, m_len, m_div;
  bit m_strobe, m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_beat = 0; m_left = 0; m_len = 0; m_div = 0;
    m_strobe = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step();
    m_strobe = 1'b0;
    m_done   = 1'b0;
    if (bus.stop) begin
      m_mode = 0;
      m_beat = 0;
    end else if (bus.play) begin
      if (m_mode == 2) begin
        m_mode = 1;
      end else if (bus.song_len != 0) begin
        m_mode   = 1;
        m_len    = int'(bus.song_len);
        m_div    = int'(bus.tempo_div);
        m_beat   = 0;
        m_left   = m_div + 1;
        m_strobe = 1'b1;
      end else if (m_mode == 1) begin
        m_mode = 0;
        m_beat = 0;
      end
    end else if (bus.pause) begin
      if (m_mode == 1) m_mode = 2;
      else if (m_mode == 2) m_mode = 1;
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_left = m_div + 1;
        if (m_beat + 1 < m_len) begin
          m_beat++;
          m_strobe = 1'b1;
        end else if (bus.loop) begin
          m_beat   = 0;
          m_strobe = 1'b1;
          m_done   = 1'b1;
        end else begin
          m_beat = m_len;
          m_done = 1'b1;
          m_mode = 0;
        end
      end
    end
  endtask

  task automatic compare_all(input string where);
    check({where, ".ibeat"},   32'(bus.ibeat),       32'(m_beat));
    check({where, ".strobe"},  32'(bus.beat_strobe), 32'(m_strobe));
    check({where, ".playing"}, 32'(bus.playing),     32'(m_mode == 1));
    check({where, ".paused"},  32'(bus.paused),      32'(m_mode == 2));
    check({where, ".done"},    32'(bus.done),        32'(m_done));
  endtask

  // One clock with the given command pulses; pulses are released afterwards.
  task automatic cycle(input bit p_play, input bit p_pause, input bit p_stop);
    bus.play  = p_play;
    bus.pause = p_pause;
    bus.stop  = p_stop;
    @(posedge clk);
    model_step();
    #1;
    compare_all("cyc");
    bus.play  = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset between edges, held across one edge with a play pulse that must be dropped.
  task automatic do_reset();
    bus.play = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst_async");
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    bus.play = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    bus.play = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
    bus.song_len = '0; bus.tempo_div = '0;
    model_reset();
    #1;
    compare_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);

    // One-shot song of 4 beats, 3 cycles each.
    bus.song_len = 8'd4; bus.tempo_div = 24'd2; bus.loop = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    check("oneshot_start", 32'(bus.ibeat), 32'd0);
    idle(12);
    check("oneshot_end_beat", 32'(bus.ibeat), 32'd4);
    check("oneshot_end_done", 32'(bus.done), 32'd1);
    check("oneshot_end_playing", 32'(bus.playing), 32'd0);
    idle(20);
    check("oneshot_hold", 32'(bus.ibeat), 32'd4);

    // Looping every cycle, then loop dropped during the second pass.
    bus.song_len = 8'd3; bus.tempo_div = 24'd0; bus.loop = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    idle(4);
    check("loop_pass2", 32'(bus.ibeat), 32'd1);
    bus.loop = 1'b0;
    idle(2);
    check("loop_end_beat", 32'(bus.ibeat), 32'd3);
    check("loop_end_done", 32'(bus.done), 32'd1);
    check("loop_end_playing", 32'(bus.playing), 32'd0);

    // Pause mid-beat, hold, resume: remaining period continues.
    bus.song_len = 8'd8; bus.tempo_div = 24'd4;
    cycle(1'b1, 1'b0, 1'b0);
    idle(10);
    check("pause_at_beat2", 32'(bus.ibeat), 32'd2);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0);
    check("pause_flag", 32'(bus.paused), 32'd1);
    idle(10);
    check("pause_frozen", 32'(bus.ibeat), 32'd2);
    check("pause_still", 32'(bus.paused), 32'd1);
    cycle(1'b1, 1'b0, 1'b0);
    idle(2);
    check("resume_not_yet", 32'(bus.ibeat), 32'd2);
    idle(1);
    check("resume_beat3", 32'(bus.ibeat), 32'd3);
    check("resume_strobe", 32'(bus.beat_strobe), 32'd1);
    cycle(1'b0, 1'b0, 1'b1);

    // Command priority.
    bus.song_len = 8'd5; bus.tempo_div = 24'd1;
    cycle(1'b1, 1'b0, 1'b0);
    idle(3);
    cycle(1'b1, 1'b0, 1'b1);
    check("stop_over_play_beat", 32'(bus.ibeat), 32'd0);
    check("stop_over_play_state", 32'(bus.playing), 32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    check("play_over_pause", 32'(bus.playing), 32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    bus.song_len = 8'd0;
    cycle(1'b1, 1'b0, 1'b0);
    check("zero_len_ignored", 32'(bus.playing), 32'd0);

    // Restart and stop coincident with the final beat advance.
    bus.song_len = 8'd2; bus.tempo_div = 24'd1; bus.loop = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    idle(3);
    cycle(1'b1, 1'b0, 1'b0);
    check("restart_final_beat", 32'(bus.ibeat), 32'd0);
    check("restart_final_playing", 32'(bus.playing), 32'd1);
    check("restart_final_done", 32'(bus.done), 32'd0);
    idle(3);
    cycle(1'b0, 1'b0, 1'b1);
    check("stop_final_done", 32'(bus.done), 32'd0);
    check("stop_final_beat", 32'(bus.ibeat), 32'd0);

    // Reset in the middle of a song.
    bus.song_len = 8'd6;
    cycle(1'b1, 1'b0, 1'b0);
    idle(5);
    do_reset();
    idle(5);

    // Randomized traffic, including parameter changes while playing and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit rp, rq, rs;
      if ($urandom_range(0, 49) == 0) bus.loop = ~bus.loop;
      bus.song_len  = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
      bus.tempo_div = 24'($urandom_range(0, 3));
      rp = ($urandom_range(0, 39) == 0);
      rq = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle(rp, rq, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
